des_key_schedule: RTL and testbench

- Sequential DES round-key generator.
- Accepts the 56-bit key after parity-bit drop (PC-1 output, C in bits 0..27, D in bits 28..55) through a valid/ready handshake.
- Produces the 16 48-bit round subkeys in round order, one per accepted output beat, for encryption or decryption.
- Contains the per-round C/D rotation logic and the existing KeyCompressionTable (PC-2). Feeds the round function's XOR stage.

---
 rtl/des_key_schedule.sv | 134 +++++++++++++
 tb/tb_des_key_schedule.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES round-key generator: loads a PC-1 key and issues the 16 PC-2 subkeys.
// Ports: clk/rst, key_in/decrypt/key_valid/key_ready load side, flush abort,
//   subkey/subkey_round/subkey_last/subkey_valid/subkey_ready issue side.
module des_key_schedule #(
    parameter bit BACK_TO_BACK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [55:0] key_in,
    input  logic        decrypt,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        flush,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_round,
    output logic        subkey_last,
    output logic        subkey_valid,
    input  logic        subkey_ready
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Entry j selects DES bit PC2[j] of C||D for subkey bit j+1.
    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    logic [0:0]  state;
    logic [55:0] cd;
    logic [3:0]  round;
    logic        mode;

    logic        load;
    logic        beat;
    logic [3:0]  next_round;
    logic        two;
    logic [55:0] step_cd;
    logic [55:0] load_cd;

    // Left rotate: new[i] = old[i+s]; index 0 is the first DES bit.
    function automatic logic [27:0] rotl(
        input logic [27:0] v,
        input logic        by2
    );
        return by2 ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [27:0] rotr(
        input logic [27:0] v,
        input logic        by2
    );
        return by2 ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    assign beat       = subkey_valid & subkey_ready;
    assign load       = key_valid & key_ready;
    assign next_round = round + 4'd1;

    // Both directions shift by one entering rounds 1, 8 and 15, else by two.
    assign two = !(next_round == 4'd1 ||
                   next_round == 4'd8 ||
                   next_round == 4'd15);

    always_comb begin
        step_cd = {rotl(cd[55:28], two), rotl(cd[27:0], two)};
        if (mode) begin
            step_cd = {rotr(cd[55:28], two), rotr(cd[27:0], two)};
        end
    end

    // Decrypt starts from C16D16, which equals the unrotated key.
    always_comb begin
        load_cd = {rotl(key_in[55:28], 1'b0), rotl(key_in[27:0], 1'b0)};
        if (decrypt) begin
            load_cd = key_in;
        end
    end

    always_comb begin
        key_ready = (state == S_IDLE);
        if (BACK_TO_BACK && state == S_RUN &&
            round == 4'd15 && subkey_ready) begin
            key_ready = 1'b1;
        end
        if (flush) begin
            key_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cd    <= '0;
            round <= '0;
            mode  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            round <= '0;
        end else if (load) begin
            state <= S_RUN;
            cd    <= load_cd;
            round <= '0;
            mode  <= decrypt;
        end else if (beat) begin
            if (round == 4'd15) begin
                state <= S_IDLE;
                round <= '0;
            end else begin
                round <= next_round;
                cd    <= step_cd;
            end
        end
    end

    always_comb begin
        subkey = '0;
        for (int j = 0; j < 48; j++) begin
            subkey[j] = cd[6'(PC2[j] - 1)];
        end
    end

    assign subkey_valid = (state == S_RUN);
    assign subkey_round = round;
    assign subkey_last  = (state == S_RUN) && (round == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule.
// Table vectors, random backpressure, back-to-back load, flush and reset.
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic [55:0] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic        flush;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_last;
    logic        subkey_valid;
    logic        subkey_ready;

    int nvec;
    int nerr;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .flush        (flush),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_last  (subkey_last),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int PC2T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    typedef struct {
        logic [55:0] key;
        logic        dec;
        int          rnd;
        logic [47:0] exp;
    } vec_t;

    logic [47:0] got [16];

    // Hex strings are written DES bit 1 first (MSB).
    function automatic logic [55:0] rev56(input logic [55:0] h);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[i] = h[55-i];
        return o;
    endfunction

    function automatic logic [47:0] to_hex48(input logic [47:0] s);
        logic [47:0] o;
        for (int j = 0; j < 48; j++) o[47-j] = s[j];
        return o;
    endfunction

    // Encryption subkey K_n (n = 1..16) from the textbook definition.
    function automatic logic [47:0] ref_k(input logic [55:0] h, input int n);
        int cum;
        int b [57];
        int r [57];
        logic [47:0] k;
        cum = 0;
        for (int i = 0; i < n; i++) cum += SHIFTS[i];
        for (int q = 1; q <= 56; q++) b[q] = int'(h[56-q]);
        b[0] = 0;
        r[0] = 0;
        for (int q = 1; q <= 28; q++) r[q] = b[((q - 1 + cum) % 28) + 1];
        for (int q = 29; q <= 56; q++) r[q] = b[((q - 29 + cum) % 28) + 29];
        k = '0;
        for (int j = 1; j <= 48; j++) k[48-j] = r[PC2T[j-1]][0];
        return k;
    endfunction

    function automatic logic [47:0] ref_issue(
        input logic [55:0] h, input logic dec, input int r);
        return dec ? ref_k(h, 16 - r) : ref_k(h, r + 1);
    endfunction

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] rnd56();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[55:0];
    endfunction

    // Called just after a rising edge with the block idle.
    task automatic load(input logic [55:0] h, input logic dec);
        key_in    = rev56(h);
        decrypt   = dec;
        key_valid = 1'b1;
        subkey_ready = 1'b0;
        @(negedge clk);
        check("load_ready", key_ready, 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_in    = rnd56();
        decrypt   = ~dec;
    endtask

    task automatic collect(input logic [55:0] h, input logic dec,
                           input int pct, input int nbeats,
                           input bit b2b, input logic [55:0] h2,
                           input logic dec2);
        int beats;
        int cyc;
        bit stalled;
        logic [47:0] hold_k;
        logic [3:0]  hold_r;
        beats = 0;
        cyc = 0;
        stalled = 0;
        hold_k = '0;
        hold_r = '0;
        while (beats < nbeats && cyc < 400) begin
            cyc++;
            subkey_ready = ($urandom_range(99) < pct);
            if (b2b && beats == 15) begin
                subkey_ready = 1'b1;
                key_valid = 1'b1;
                key_in = rev56(h2);
                decrypt = dec2;
            end else begin
                key_in = rnd56();
                decrypt = $urandom_range(1);
            end
            @(negedge clk);
            check("valid", subkey_valid, 1);
            if (stalled) begin
                check("stall_key", subkey, hold_k);
                check("stall_round", subkey_round, hold_r);
            end
            check("round", subkey_round, beats);
            check("last", subkey_last, beats == 15);
            check("subkey", to_hex48(subkey), ref_issue(h, dec, beats));
            if (b2b && beats == 15) check("b2b_ready", key_ready, 1);
            if (subkey_ready) begin
                got[beats] = to_hex48(subkey);
                beats++;
                stalled = 0;
            end else begin
                stalled = 1;
                hold_k = subkey;
                hold_r = subkey_round;
            end
            @(posedge clk);
            #1;
            key_valid = 1'b0;
        end
        if (beats < nbeats) check("timeout", beats, nbeats);
        if (nbeats == 16 && !b2b) begin
            subkey_ready = 1'b0;
            @(negedge clk);
            check("end_valid", subkey_valid, 0);
            check("end_ready", key_ready, 1);
            check("end_last", subkey_last, 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic full(input logic [55:0] h, input logic dec, input int pct);
        load(h, dec);
        collect(h, dec, pct, 16, 0, '0, 1'b0);
    endtask

    localparam logic [55:0] K0 = 56'hF0CCAAF556678F;

    vec_t tbl [6];
    logic [55:0] ka;
    logic [55:0] kb;

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        key_in = '0;
        decrypt = 1'b0;
        key_valid = 1'b0;
        flush = 1'b0;
        subkey_ready = 1'b0;

        tbl[0] = '{K0, 1'b0, 0,  48'h1B02EFFC7072};
        tbl[1] = '{K0, 1'b0, 1,  48'h79AED9DBC9E5};
        tbl[2] = '{K0, 1'b0, 15, 48'hCB3D8B0E17F5};
        tbl[3] = '{K0, 1'b1, 0,  48'hCB3D8B0E17F5};
        tbl[4] = '{K0, 1'b1, 14, 48'h79AED9DBC9E5};
        tbl[5] = '{K0, 1'b1, 15, 48'h1B02EFFC7072};

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_valid", subkey_valid, 0);
        check("rst_ready", key_ready, 1);
        check("rst_last", subkey_last, 0);
        check("rst_round", subkey_round, 0);
        check("rst_subkey", subkey, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            full(tbl[i].key, tbl[i].dec, 100);
            check("table", got[tbl[i].rnd], tbl[i].exp);
        end

        for (int i = 0; i < 6; i++) begin
            full(rnd56(), 1'(i), 50);
        end

        ka = rnd56();
        kb = rnd56();
        load(ka, 1'b0);
        collect(ka, 1'b0, 100, 16, 1, kb, 1'b1);
        collect(kb, 1'b1, 100, 16, 0, '0, 1'b0);

        ka = rnd56();
        load(ka, 1'b1);
        collect(ka, 1'b1, 100, 7, 0, '0, 1'b0);
        flush = 1'b1;
        key_valid = 1'b1;
        key_in = rnd56();
        subkey_ready = 1'b1;
        @(negedge clk);
        check("flush_round7", subkey_round, 7);
        check("flush_ready0", key_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        key_valid = 1'b0;
        subkey_ready = 1'b0;
        @(negedge clk);
        check("flush_valid", subkey_valid, 0);
        check("flush_ready", key_ready, 1);
        check("flush_round", subkey_round, 0);
        @(posedge clk);
        #1;
        full(K0, 1'b0, 100);
        check("post_flush", got[15], 48'hCB3D8B0E17F5);

        ka = rnd56();
        load(ka, 1'b0);
        collect(ka, 1'b0, 100, 7, 0, '0, 1'b0);
        rst = 1'b1;
        subkey_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        subkey_ready = 1'b0;
        @(negedge clk);
        check("rst2_valid", subkey_valid, 0);
        check("rst2_ready", key_ready, 1);
        check("rst2_last", subkey_last, 0);
        check("rst2_round", subkey_round, 0);
        check("rst2_subkey", subkey, 0);
        @(posedge clk);
        #1;
        full(K0, 1'b1, 50);
        check("post_rst", got[0], 48'hCB3D8B0E17F5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
